// File: rtl/atcnet_pkg.sv
// Shared state encoding, data types and default sizing for the ATCNet window scheduler.
package atcnet_pkg;

   localparam int DEF_DATA_WIDTH      = 16;
   localparam int DEF_RES_WIDTH       = 32;
   localparam int DEF_WINDOW_SIZE     = 32;
   localparam int DEF_RESULTS_PER_WIN = 1;
   localparam int DEF_TIMEOUT_CYC     = 1024;
   localparam int DEF_CNT_WIDTH       = 16;

   typedef enum logic [2:0] {IDLE, FILL, DRAIN, DONE, ERR} sched_state_e;

   typedef logic signed [DEF_DATA_WIDTH-1:0] sample_t;
   typedef logic        [DEF_RES_WIDTH-1:0]  result_t;

endpackage

// File: rtl/sched_watchdog.sv
// DRAIN-phase result watchdog: reloads on i_load, counts down while enabled, and flags
// expiry once TIMEOUT_CYC-1 idle cycles have elapsed since the last load.
module sched_watchdog #(
   parameter int TIMEOUT_CYC = 1024
) (
   input  logic clk,
   input  logic rst_n,
   input  logic i_load,
   input  logic i_en,
   output logic o_expire
);
   localparam int              WD_W    = $clog2(TIMEOUT_CYC);
   localparam logic [WD_W-1:0] WD_LOAD = WD_W'(TIMEOUT_CYC - 1);
   localparam logic [WD_W-1:0] WD_ONE  = WD_W'(1);

   logic [WD_W-1:0] r_cnt;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_cnt <= '0;
      end else if (i_load) begin
         r_cnt <= WD_LOAD;
      end else if (i_en && (r_cnt != '0)) begin
         r_cnt <= r_cnt - WD_ONE;
      end
   end

   assign o_expire = (r_cnt == '0);

endmodule

// File: rtl/atcnet_window_scheduler.sv
// Frame sequencer ahead of the ATCNet window chain: admits WINDOW_SIZE samples per window,
// waits for the chain's results, repeats num_windows times, and flushes on abort or timeout.
module atcnet_window_scheduler
   import atcnet_pkg::*;
#(
   parameter int DATA_WIDTH      = DEF_DATA_WIDTH,
   parameter int RES_WIDTH       = DEF_RES_WIDTH,
   parameter int WINDOW_SIZE     = DEF_WINDOW_SIZE,
   parameter int RESULTS_PER_WIN = DEF_RESULTS_PER_WIN,
   parameter int TIMEOUT_CYC     = DEF_TIMEOUT_CYC,
   parameter int CNT_WIDTH       = DEF_CNT_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic                  abort,
   input  logic [CNT_WIDTH-1:0]  num_windows,
   output logic                  busy,
   output logic                  done,
   output logic                  timeout_err,
   output logic [CNT_WIDTH-1:0]  win_count,
   input  logic                  s_valid,
   output logic                  s_ready,
   input  logic [DATA_WIDTH-1:0] s_sample,
   output logic                  pipe_valid,
   output logic [DATA_WIDTH-1:0] pipe_sample,
   output logic                  pipe_flush,
   input  logic                  res_valid,
   input  logic [RES_WIDTH-1:0]  res_data,
   output logic                  m_valid,
   output logic [RES_WIDTH-1:0]  m_data,
   output logic                  m_last
);
   // state | meaning
   // IDLE  | waiting for start; source stalled
   // FILL  | forwarding samples of the current window
   // DRAIN | source stalled; collecting chain results under watchdog
   // DONE  | frame complete; done pulses on the following cycle
   // ERR   | watchdog expired; flush the chain and raise timeout_err

   localparam int                   SAMP_W    = $clog2(WINDOW_SIZE);
   localparam int                   RES_W     = $clog2(RESULTS_PER_WIN + 1);
   localparam logic [SAMP_W-1:0]    SAMP_LAST = SAMP_W'(WINDOW_SIZE - 1);
   localparam logic [SAMP_W-1:0]    SAMP_ONE  = SAMP_W'(1);
   localparam logic [RES_W-1:0]     RES_LAST  = RES_W'(RESULTS_PER_WIN - 1);
   localparam logic [RES_W-1:0]     RES_ONE   = RES_W'(1);
   localparam logic [CNT_WIDTH-1:0] CNT_ONE   = CNT_WIDTH'(1);

   sched_state_e          r_state, w_next;
   logic [CNT_WIDTH-1:0]  r_num_win, r_win_cnt;
   logic [SAMP_W-1:0]     r_samp_cnt;
   logic [RES_W-1:0]      r_res_cnt;
   logic                  r_busy, r_done, r_timeout_err, r_s_ready, r_pipe_valid;
   logic                  r_pipe_flush, r_m_valid, r_m_last;
   logic [DATA_WIDTH-1:0] r_pipe_sample;
   logic [RES_WIDTH-1:0]  r_m_data;
   logic                  w_s_hs, w_r_hs, w_win_end, w_frame_end, w_abort;
   logic                  w_start_ok, w_start_zero, w_wd_expire;

   assign w_s_hs       = s_valid && r_s_ready;
   assign w_r_hs       = res_valid && (r_state == DRAIN);
   assign w_win_end    = w_r_hs && (r_res_cnt == RES_LAST);
   assign w_frame_end  = w_win_end && (r_win_cnt == (r_num_win - CNT_ONE));
   assign w_abort      = abort && (r_state != IDLE);
   assign w_start_ok   = (r_state == IDLE) && start && (num_windows != '0);
   assign w_start_zero = (r_state == IDLE) && start && (num_windows == '0);

   sched_watchdog #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_watchdog (
      .clk      (clk),
      .rst_n    (rst_n),
      .i_load   ((r_state != DRAIN) || w_r_hs),
      .i_en     (r_state == DRAIN),
      .o_expire (w_wd_expire)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    if (w_start_ok) w_next = FILL;
         FILL:    if (w_s_hs && (r_samp_cnt == SAMP_LAST)) w_next = DRAIN;
         DRAIN: begin
            // a result landing on the expiry cycle still counts
            if (w_win_end)                     w_next = w_frame_end ? DONE : FILL;
            else if (!res_valid && w_wd_expire) w_next = ERR;
         end
         DONE:    w_next = IDLE;
         ERR:     w_next = IDLE;
         default: w_next = IDLE;
      endcase
      if (w_abort) w_next = IDLE;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_num_win     <= '0;
         r_win_cnt     <= '0;
         r_samp_cnt    <= '0;
         r_res_cnt     <= '0;
         r_busy        <= 1'b0;
         r_done        <= 1'b0;
         r_timeout_err <= 1'b0;
         r_s_ready     <= 1'b0;
         r_pipe_valid  <= 1'b0;
         r_pipe_sample <= '0;
         r_pipe_flush  <= 1'b0;
         r_m_valid     <= 1'b0;
         r_m_data      <= '0;
         r_m_last      <= 1'b0;
      end else begin
         r_s_ready    <= (w_next == FILL);
         r_busy       <= (w_next == FILL) || (w_next == DRAIN);
         r_pipe_valid <= w_s_hs && !w_abort;
         r_m_valid    <= w_r_hs && !w_abort;
         r_m_last     <= w_frame_end && !w_abort;
         r_done       <= ((r_state == DONE) && !w_abort) || w_start_zero;
         r_pipe_flush <= w_abort || (r_state == ERR);
         if (w_s_hs) r_pipe_sample <= s_sample;
         if (w_r_hs) r_m_data      <= res_data;

         if (start && (r_state == IDLE))       r_timeout_err <= 1'b0;
         else if ((r_state == ERR) && !w_abort) r_timeout_err <= 1'b1;

         if (w_start_ok) begin
            r_num_win  <= num_windows;
            r_win_cnt  <= '0;
            r_samp_cnt <= '0;
            r_res_cnt  <= '0;
         end else if (w_s_hs && !w_abort) begin
            r_samp_cnt <= (r_samp_cnt == SAMP_LAST) ? '0 : r_samp_cnt + SAMP_ONE;
         end else if (w_r_hs && !w_abort) begin
            if (w_win_end) begin
               r_res_cnt <= '0;
               r_win_cnt <= r_win_cnt + CNT_ONE;
            end else begin
               r_res_cnt <= r_res_cnt + RES_ONE;
            end
         end
      end
   end

   assign busy        = r_busy;
   assign done        = r_done;
   assign timeout_err = r_timeout_err;
   assign win_count   = r_win_cnt;
   assign s_ready     = r_s_ready;
   assign pipe_valid  = r_pipe_valid;
   assign pipe_sample = r_pipe_sample;
   assign pipe_flush  = r_pipe_flush;
   assign m_valid     = r_m_valid;
   assign m_data      = r_m_data;
   assign m_last      = r_m_last;

endmodule

// File: tb/tb_atcnet_window_scheduler.sv
// Randomized self-checking bench for atcnet_window_scheduler: a source/chain model drives
// frames while a negedge monitor records what the scheduler emits.
module tb_atcnet_window_scheduler;
   localparam int DW = 16, RW = 32, WS = 32, RPW = 1, TO = 1024, CW = 16;

   logic          clk = 1'b0;
   logic          rst_n, start, abort;
   logic [CW-1:0] num_windows;
   logic          busy, done, timeout_err;
   logic [CW-1:0] win_count;
   logic          s_valid, s_ready;
   logic [DW-1:0] s_sample;
   logic          pipe_valid, pipe_flush;
   logic [DW-1:0] pipe_sample;
   logic          res_valid;
   logic [RW-1:0] res_data;
   logic          m_valid, m_last;
   logic [RW-1:0] m_data;

   always #5 clk = ~clk;

   atcnet_window_scheduler #(
      .DATA_WIDTH(DW), .RES_WIDTH(RW), .WINDOW_SIZE(WS),
      .RESULTS_PER_WIN(RPW), .TIMEOUT_CYC(TO), .CNT_WIDTH(CW)
   ) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .num_windows(num_windows),
      .busy(busy), .done(done), .timeout_err(timeout_err), .win_count(win_count),
      .s_valid(s_valid), .s_ready(s_ready), .s_sample(s_sample),
      .pipe_valid(pipe_valid), .pipe_sample(pipe_sample), .pipe_flush(pipe_flush),
      .res_valid(res_valid), .res_data(res_data),
      .m_valid(m_valid), .m_data(m_data), .m_last(m_last)
   );

   int n_checks = 0, n_pass = 0;

   // Monitor: everything the scheduler emits, cycle-stamped.
   int            cyc = 0;
   logic [DW-1:0] pipe_q[$];
   logic [RW-1:0] mres_q[$];
   int n_mlast = 0, mlast_cyc = -1, mvalid_last_cyc = -1;
   int n_done = 0, done_cyc = -1, n_flush = 0, n_drain = 0;

   always @(negedge clk) begin
      cyc <= cyc + 1;
      if (pipe_valid) pipe_q.push_back(pipe_sample);
      if (m_valid) begin
         mres_q.push_back(m_data);
         mvalid_last_cyc <= cyc;
      end
      if (m_last) begin
         n_mlast   <= n_mlast + 1;
         mlast_cyc <= cyc;
      end
      if (done) begin
         n_done   <= n_done + 1;
         done_cyc <= cyc;
      end
      if (pipe_flush)        n_flush <= n_flush + 1;
      if (busy && !s_ready)  n_drain <= n_drain + 1;
   end

   logic rdy_seen = 1'b0;
   logic hs_last  = 1'b0;

   task automatic tick();
      hs_last = s_valid && rdy_seen;
      @(posedge clk);
      #1;
      rdy_seen = s_ready;
   endtask

   // Source + chain model: the source offers samples in order, the chain answers each
   // completed window of WS pipe samples with one result res_delay edges later.
   logic [DW-1:0] src[$];
   logic [RW-1:0] exp_res[$];
   int   fr_drain_viol;
   bit   fr_done;
   logic fr_terr_after_start;

   task automatic run_frame(input int n, input int gap_pct, input int res_delay,
                            input bit give_res, input bit stray,
                            input int stop_after_drain, input int budget);
      int idx = 0, chain_cnt = 0, pend = -1, drain_cyc = 0;
      int total = WS * n;
      bit drain = 1'b0;
      src.delete();
      exp_res.delete();
      for (int i = 0; i < total + 4; i++) src.push_back(DW'($urandom));
      fr_drain_viol = 0;
      fr_done = 1'b0;
      num_windows = CW'(n);
      s_valid = 1'b0;
      res_valid = 1'b0;
      start = 1'b1;
      tick();
      start = 1'b0;
      fr_terr_after_start = timeout_err;
      for (int c = 0; c < budget; c++) begin
         s_valid = 1'b0;
         s_sample = '0;
         if (idx < total + 4) begin
            s_valid  = ($urandom_range(0, 99) >= gap_pct);
            s_sample = src[idx];
         end
         res_valid = 1'b0;
         res_data  = RW'($urandom);
         if (drain && pend >= 0) begin
            if (pend == 0) begin
               res_valid = 1'b1;
               exp_res.push_back(res_data);
               drain = 1'b0;
               pend  = -1;
            end else begin
               pend--;
            end
         end else if (!drain && stray) begin
            res_valid = ($urandom_range(0, 1) == 1);
         end
         tick();
         if (hs_last) idx++;
         if (pipe_valid) begin
            chain_cnt++;
            if (chain_cnt == WS) begin
               chain_cnt = 0;
               drain     = 1'b1;
               drain_cyc = 0;
               if (give_res) pend = res_delay - 1;
            end
         end
         if (drain) begin
            if (s_ready) fr_drain_viol++;
            drain_cyc++;
            if (stop_after_drain > 0 && drain_cyc >= stop_after_drain) break;
         end
         if (done) begin
            fr_done = 1'b1;
            break;
         end
         if (pipe_flush) break;
      end
      s_valid = 1'b0;
      res_valid = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; start = 1'b0; abort = 1'b0; num_windows = '0;
      s_valid = 1'b0; s_sample = '0; res_valid = 1'b0; res_data = '0;
      repeat (3) tick();
      n_checks++;
      if ({busy, done, timeout_err, s_ready, pipe_valid, pipe_flush, m_valid, m_last} !== 8'h00)
         $display("FAIL reset_ctrl: got %b expected 00000000",
                  {busy, done, timeout_err, s_ready, pipe_valid, pipe_flush, m_valid, m_last});
      else n_pass++;
      n_checks++;
      if ({win_count, pipe_sample, m_data} !== '0)
         $display("FAIL reset_data: win_count=%0d pipe_sample=%0h m_data=%0h expected all 0",
                  win_count, pipe_sample, m_data);
      else n_pass++;
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_two_windows();
      int b_pipe = pipe_q.size(), b_m = mres_q.size(), b_done = n_done, b_last = n_mlast;
      int mis = 0;
      run_frame(2, 0, 5, 1'b1, 1'b0, 0, 400);
      repeat (4) tick();
      n_checks++;
      if (fr_done !== 1'b1) $display("FAIL two_win_done_seen: got %0d expected 1", fr_done);
      else n_pass++;
      n_checks++;
      if (pipe_q.size() - b_pipe != 2 * WS)
         $display("FAIL two_win_pipe_count: got %0d expected %0d", pipe_q.size() - b_pipe, 2 * WS);
      else n_pass++;
      for (int i = 0; i < 2 * WS; i++)
         if (b_pipe + i >= pipe_q.size() || pipe_q[b_pipe + i] !== src[i]) mis++;
      n_checks++;
      if (mis != 0) $display("FAIL two_win_pipe_data: got %0d bad samples expected 0", mis);
      else n_pass++;
      n_checks++;
      if (mres_q.size() - b_m != 2)
         $display("FAIL two_win_m_count: got %0d expected 2", mres_q.size() - b_m);
      else n_pass++;
      mis = 0;
      for (int i = 0; i < exp_res.size(); i++)
         if (b_m + i >= mres_q.size() || mres_q[b_m + i] !== exp_res[i]) mis++;
      n_checks++;
      if (mis != 0 || exp_res.size() != 2)
         $display("FAIL two_win_m_data: got %0d bad of %0d expected 0 bad of 2", mis, exp_res.size());
      else n_pass++;
      n_checks++;
      if (n_mlast - b_last != 1 || mlast_cyc != mvalid_last_cyc)
         $display("FAIL two_win_m_last: got count %0d at cyc %0d expected 1 at cyc %0d",
                  n_mlast - b_last, mlast_cyc, mvalid_last_cyc);
      else n_pass++;
      n_checks++;
      if (n_done - b_done != 1 || done_cyc - mlast_cyc != 1)
         $display("FAIL two_win_done_pulse: got count %0d offset %0d expected 1 and 1",
                  n_done - b_done, done_cyc - mlast_cyc);
      else n_pass++;
      n_checks++;
      if (win_count !== CW'(2)) $display("FAIL two_win_win_count: got %0d expected 2", win_count);
      else n_pass++;
      n_checks++;
      if (fr_drain_viol != 0)
         $display("FAIL two_win_s_ready_drain: got %0d ready cycles expected 0", fr_drain_viol);
      else n_pass++;
      n_checks++;
      if (busy !== 1'b0) $display("FAIL two_win_busy_after: got %0d expected 0", busy);
      else n_pass++;
   endtask

   task automatic test_zero_windows();
      int b_pipe = pipe_q.size(), b_done = n_done;
      int busy_seen = 0;
      num_windows = '0;
      start = 1'b1;
      tick();
      start = 1'b0;
      n_checks++;
      if (done !== 1'b1) $display("FAIL zero_done_next: got %0d expected 1", done);
      else n_pass++;
      if (busy) busy_seen++;
      for (int i = 0; i < 6; i++) begin
         tick();
         if (busy) busy_seen++;
      end
      n_checks++;
      if (n_done - b_done != 1) $display("FAIL zero_done_count: got %0d expected 1", n_done - b_done);
      else n_pass++;
      n_checks++;
      if (busy_seen != 0) $display("FAIL zero_busy: got %0d busy cycles expected 0", busy_seen);
      else n_pass++;
      n_checks++;
      if (pipe_q.size() != b_pipe)
         $display("FAIL zero_pipe: got %0d pipe_valid expected 0", pipe_q.size() - b_pipe);
      else n_pass++;
   endtask

   task automatic test_timeout();
      int b_flush = n_flush, b_done = n_done, b_drain = n_drain, b_m = mres_q.size();
      run_frame(1, 20, 1, 1'b0, 1'b0, 0, 1400);
      repeat (3) tick();
      n_checks++;
      if (n_flush - b_flush != 1) $display("FAIL to_flush: got %0d pulses expected 1", n_flush - b_flush);
      else n_pass++;
      n_checks++;
      if (n_drain - b_drain != TO)
         $display("FAIL to_drain_cycles: got %0d expected %0d", n_drain - b_drain, TO);
      else n_pass++;
      n_checks++;
      if (timeout_err !== 1'b1) $display("FAIL to_err_set: got %0d expected 1", timeout_err);
      else n_pass++;
      n_checks++;
      if (n_done != b_done || mres_q.size() != b_m)
         $display("FAIL to_no_done: got done %0d m_valid %0d expected 0 and 0",
                  n_done - b_done, mres_q.size() - b_m);
      else n_pass++;
      repeat (50) tick();
      n_checks++;
      if (timeout_err !== 1'b1 || busy !== 1'b0)
         $display("FAIL to_err_sticky: got err %0d busy %0d expected 1 and 0", timeout_err, busy);
      else n_pass++;
   endtask

   task automatic test_threshold();
      int b_flush = n_flush, b_done = n_done, b_m = mres_q.size();
      run_frame(1, 0, TO, 1'b1, 1'b0, 0, 1400);
      repeat (4) tick();
      n_checks++;
      if (fr_terr_after_start !== 1'b0)
         $display("FAIL thr_err_cleared_by_start: got %0d expected 0", fr_terr_after_start);
      else n_pass++;
      n_checks++;
      if (mres_q.size() - b_m != 1 || exp_res.size() != 1)
         $display("FAIL thr_m_count: got %0d expected 1", mres_q.size() - b_m);
      else n_pass++;
      n_checks++;
      if (exp_res.size() != 1 || b_m >= mres_q.size() || mres_q[b_m] !== exp_res[0])
         $display("FAIL thr_m_data: got %0d results, first mismatch expected match", mres_q.size() - b_m);
      else n_pass++;
      n_checks++;
      if (timeout_err !== 1'b0 || n_flush != b_flush)
         $display("FAIL thr_no_timeout: got err %0d flush %0d expected 0 and 0",
                  timeout_err, n_flush - b_flush);
      else n_pass++;
      n_checks++;
      if (n_done - b_done != 1) $display("FAIL thr_done: got %0d expected 1", n_done - b_done);
      else n_pass++;
   endtask

   task automatic test_abort();
      int b_flush = n_flush, b_done = n_done, b_pipe = pipe_q.size();
      int hs = 0, mis = 0;
      num_windows = CW'(3);
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int c = 0; c < 200 && hs < 10; c++) begin
         s_valid  = ($urandom_range(0, 1) == 1);
         s_sample = DW'($urandom);
         tick();
         if (hs_last) hs++;
      end
      s_valid = 1'b0;
      abort = 1'b1;
      tick();
      abort = 1'b0;
      n_checks++;
      if (pipe_flush !== 1'b1) $display("FAIL abort_flush_now: got %0d expected 1", pipe_flush);
      else n_pass++;
      repeat (4) tick();
      n_checks++;
      if (n_flush - b_flush != 1) $display("FAIL abort_flush_count: got %0d expected 1", n_flush - b_flush);
      else n_pass++;
      n_checks++;
      if (busy !== 1'b0 || s_ready !== 1'b0 || n_done != b_done)
         $display("FAIL abort_idle: got busy %0d s_ready %0d done %0d expected 0 0 0",
                  busy, s_ready, n_done - b_done);
      else n_pass++;
      n_checks++;
      if (pipe_q.size() - b_pipe != 10)
         $display("FAIL abort_pipe_count: got %0d expected 10", pipe_q.size() - b_pipe);
      else n_pass++;
      n_checks++;
      if (timeout_err !== 1'b0) $display("FAIL abort_err_unchanged: got %0d expected 0", timeout_err);
      else n_pass++;
      b_pipe = pipe_q.size();
      b_done = n_done;
      run_frame(1, 30, 3, 1'b1, 1'b0, 0, 400);
      repeat (4) tick();
      for (int i = 0; i < WS; i++)
         if (b_pipe + i >= pipe_q.size() || pipe_q[b_pipe + i] !== src[i]) mis++;
      n_checks++;
      if (mis != 0 || pipe_q.size() - b_pipe != WS)
         $display("FAIL restart_pipe: got %0d samples %0d bad expected %0d and 0",
                  pipe_q.size() - b_pipe, mis, WS);
      else n_pass++;
      n_checks++;
      if (n_done - b_done != 1 || win_count !== CW'(1))
         $display("FAIL restart_done: got done %0d win_count %0d expected 1 and 1",
                  n_done - b_done, win_count);
      else n_pass++;
   endtask

   task automatic test_reset_mid_drain();
      int b_m = mres_q.size(), b_done = n_done, b_flush = n_flush;
      for (int i = 0; i < 5; i++) begin
         res_valid = 1'b1;
         res_data  = RW'($urandom);
         tick();
      end
      res_valid = 1'b0;
      run_frame(2, 30, 1, 1'b0, 1'b1, 8, 500);
      n_checks++;
      if (busy !== 1'b1 || s_ready !== 1'b0)
         $display("FAIL rst_in_drain: got busy %0d s_ready %0d expected 1 and 0", busy, s_ready);
      else n_pass++;
      n_checks++;
      if (mres_q.size() != b_m)
         $display("FAIL stray_dropped: got %0d m_valid expected 0", mres_q.size() - b_m);
      else n_pass++;
      rst_n = 1'b0;
      s_valid = 1'b1;
      res_valid = 1'b1;
      tick();
      n_checks++;
      if ({busy, done, timeout_err, s_ready, pipe_valid, pipe_flush, m_valid, m_last} !== 8'h00 ||
          {win_count, pipe_sample, m_data} !== '0)
         $display("FAIL rst_mid_outputs: got ctrl %b win_count %0d expected all 0",
                  {busy, done, timeout_err, s_ready, pipe_valid, pipe_flush, m_valid, m_last}, win_count);
      else n_pass++;
      s_valid = 1'b0;
      res_valid = 1'b0;
      rst_n = 1'b1;
      tick();
      n_checks++;
      if (n_done != b_done || n_flush != b_flush)
         $display("FAIL rst_mid_no_pulses: got done %0d flush %0d expected 0 and 0",
                  n_done - b_done, n_flush - b_flush);
      else n_pass++;
      b_m = mres_q.size();
      run_frame(1, 30, 2, 1'b1, 1'b1, 0, 400);
      repeat (4) tick();
      n_checks++;
      if (fr_done !== 1'b1 || mres_q.size() - b_m != 1)
         $display("FAIL post_rst_frame: got done %0d m_valid %0d expected 1 and 1",
                  fr_done, mres_q.size() - b_m);
      else n_pass++;
      n_checks++;
      if (exp_res.size() != 1 || b_m >= mres_q.size() || mres_q[b_m] !== exp_res[0])
         $display("FAIL post_rst_m_data: got %0d results expected 1 matching", mres_q.size() - b_m);
      else n_pass++;
   endtask

   initial begin
      test_reset();
      test_two_windows();
      test_zero_windows();
      test_timeout();
      test_threshold();
      test_abort();
      test_reset_mid_drain();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL global_time_limit: got no finish expected finish before 1ms");
      $fatal(1, "time limit");
   end

endmodule
